// File: rtl/mannix_ddr_responder.sv
// mannix_ddr_responder: backing-store model for the memory farm DDR ports.
// Serves single-word writes and fixed-latency burst reads from a word array.
module mannix_ddr_responder #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 3,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [31:0]       rd_addr,
    input  logic [LEN_W-1:0]  rd_len,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              wr_req,
    input  logic [31:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              busy
);
    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = LEN_W + 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;

    // Byte offset bits drop out; upper bits fall off the cast so addresses wrap.
    assign rd_idx = IDX_W'(rd_addr >> OFF_W);
    assign wr_idx = IDX_W'(wr_addr >> OFF_W);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        rd_data_d = rd_data_q;
        rd_gnt    = 1'b0;
        wr_gnt    = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so they must also be held off while rst is high.
                if (!rst) begin
                    if (wr_req) begin
                        wr_gnt = 1'b1;
                    end else if (rd_req) begin
                        rd_gnt = 1'b1;
                        idx_d  = rd_idx;
                        cnt_d  = CNT_W'(rd_len) + CNT_W'(1);
                        if (RD_LAT == 1) begin
                            state_d = RD_BURST;
                        end else begin
                            state_d = RD_WAIT;
                            lat_d   = LAT_W'(RD_LAT - 1);
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_W'(1)) begin
                    state_d = RD_BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RD_BURST: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Fetch the word to be presented during the coming burst cycle.
        if (state_d == RD_BURST) begin
            rd_data_d = mem_q[idx_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            lat_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_gnt) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = (state_q == RD_BURST);
    assign rd_last  = (state_q == RD_BURST) && (cnt_q == CNT_W'(1));
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mannix_ddr_responder.sv
// Self-checking bench for mannix_ddr_responder: vector table, corner sequences
// and randomized traffic against a word-array reference model.
module tb_mannix_ddr_responder;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 3;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rd_req = 1'b0;
    logic [31:0]       rd_addr = '0;
    logic [LEN_W-1:0]  rd_len = '0;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic              wr_req = 1'b0;
    logic [31:0]       wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_gnt;
    logic              busy;

    always #5 clk = ~clk;

    mannix_ddr_responder #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .RD_LAT(RD_LAT),
        .LEN_W (LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rd_req  (rd_req),
        .rd_addr (rd_addr),
        .rd_len  (rd_len),
        .rd_gnt  (rd_gnt),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .rd_last (rd_last),
        .wr_req  (wr_req),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_gnt  (wr_gnt),
        .busy    (busy)
    );

    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
        logic [31:0] exp0;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Entered and left just after a rising edge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        while (!wr_gnt && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("wr_gnt", wr_gnt, 1);
        chk("wr_no_rd_gnt", rd_gnt, 0);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_mem[widx(a)] = d;
        known[widx(a)] = 1'b1;
    endtask

    task automatic run_read(input logic [31:0] a, input int len, input bit hold_wr,
                            input logic [31:0] wa, input logic [31:0] wd,
                            output int waited, output logic [31:0] first);
        int base = widx(a);
        int w;
        waited  = 0;
        first   = '0;
        rd_req  = 1'b1;
        rd_addr = a;
        rd_len  = LEN_W'(len);
        @(negedge clk);
        while (!rd_gnt && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("rd_gnt", rd_gnt, 1);
        chk("rd_gnt_no_wr_gnt", wr_gnt, 0);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        if (hold_wr) begin
            wr_req  = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        for (int k = 1; k < RD_LAT; k++) begin
            @(negedge clk);
            chk("lat_valid_low", rd_valid, 0);
            chk("lat_busy", busy, 1);
            chk("lat_no_gnt", {rd_gnt, wr_gnt}, 0);
        end
        for (int b = 0; b <= len; b++) begin
            @(negedge clk);
            w = (base + b) % DEPTH;
            chk("beat_valid", rd_valid, 1);
            chk("beat_last", rd_last, (b == len));
            chk("beat_busy", busy, 1);
            chk("beat_no_gnt", {rd_gnt, wr_gnt}, 0);
            if (known[w]) chk("beat_data", rd_data, model_mem[w]);
            if (b == 0) first = rd_data;
        end
        @(negedge clk);
        chk("post_valid", rd_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_data_hold", rd_data, (len >= 0 && known[(base + len) % DEPTH]) ?
            model_mem[(base + len) % DEPTH] : rd_data);
        if (hold_wr) chk("wr_gnt_after_burst", wr_gnt, 1);
        @(posedge clk);
        #1;
        if (hold_wr) begin
            wr_req = 1'b0;
            model_mem[widx(wa)] = wd;
            known[widx(wa)] = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int          waited;
        int          bad;
        int          gap;
        logic [31:0] first;
        logic [31:0] ra;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'hA5A5_0001};
        vecs[2]  = '{1'b1, 32'h0000_0013, 32'h0000_0011, 0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         0, 32'h0000_0011};
        vecs[4]  = '{1'b1, 32'h0000_4014, 32'hBEEF_0005, 0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0,         1, 32'hBEEF_0005};
        vecs[6]  = '{1'b1, 32'h0000_3FF8, 32'hDDDD_0FFE, 0, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_3FFC, 32'hDDDD_0FFF, 0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0000, 32'hDDDD_0000, 0, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0004, 32'hDDDD_0001, 0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_3FF8, 32'h0,         3, 32'hDDDD_0FFE};
        vecs[11] = '{1'b0, 32'h0000_7FF9, 32'h0,         0, 32'hDDDD_0FFE};

        // Reset state, with requests pending to show grants stay low.
        rd_req = 1'b1;
        wr_req = 1'b1;
        @(negedge clk);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rd_req = 1'b0;
        wr_req = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data);
            end else begin
                run_read(vecs[i].addr, vecs[i].len, 1'b0, '0, '0, waited, first);
                chk("vec_first_data", first, vecs[i].exp0);
                chk("vec_gnt_latency", waited, 0);
            end
        end

        // Eight-word burst of ascending data.
        for (int i = 0; i < 8; i++) do_write(32'(i * 4), 32'(i));
        run_read(32'h0, 7, 1'b0, '0, '0, waited, first);
        chk("burst8_first", first, 0);

        // Simultaneous requests: write wins, read follows next cycle with new data.
        wr_req  = 1'b1;
        wr_addr = 32'h20;
        wr_data = 32'h0000_0033;
        rd_req  = 1'b1;
        rd_addr = 32'h20;
        rd_len  = '0;
        @(negedge clk);
        chk("both_wr_gnt", wr_gnt, 1);
        chk("both_rd_gnt", rd_gnt, 0);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        model_mem[8] = 32'h0000_0033;
        known[8] = 1'b1;
        run_read(32'h20, 0, 1'b0, '0, '0, waited, first);
        chk("both_rd_next_cycle", waited, 0);
        chk("both_rd_data", first, 32'h0000_0033);

        // Write held across a burst is granted only in the IDLE cycle after rd_last.
        run_read(32'h0, 7, 1'b1, 32'h40, 32'h0000_0066, waited, first);
        run_read(32'h40, 0, 1'b0, '0, '0, waited, first);
        chk("held_wr_data", first, 32'h0000_0066);

        // Maximum burst length.
        run_read(32'h0, (1 << LEN_W) - 1, 1'b0, '0, '0, waited, first);

        // Reset on the second beat of an eight-word burst.
        rd_req  = 1'b1;
        rd_addr = 32'h0;
        rd_len  = LEN_W'(7);
        @(negedge clk);
        chk("rstmid_gnt", rd_gnt, 1);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        repeat (RD_LAT) @(negedge clk);
        chk("rstmid_beat0", rd_valid, 1);
        @(negedge clk);
        chk("rstmid_beat1", rd_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid_valid", rd_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_last", rd_last, 0);
        chk("rstmid_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rd_valid || busy) bad++;
        end
        chk("rstmid_no_more_beats", bad, 0);
        @(posedge clk);
        #1;
        run_read(32'h10, 0, 1'b0, '0, '0, waited, first);
        chk("rstmid_after_gnt", waited, 0);

        // Random traffic against the reference array.
        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 3) << 14) | $urandom_range(0, 1023);
            if ($urandom_range(0, 2) != 0) begin
                do_write(ra, $urandom);
            end else begin
                run_read(ra, $urandom_range(0, 12), 1'b0, '0, '0, waited, first);
                chk("rand_gnt_latency", waited, 0);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
